// File: rtl/pyc_rr_dist.sv
// Round-robin distributor: one input stream spread over N single-entry output slots.
// Each accepted item goes to the first available slot at or after the rotating pointer.
module pyc_rr_dist #(
  parameter int WIDTH = 1,
  parameter int N = 2,
  localparam int SEL_W = $clog2((N <= 1) ? 2 : N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic [N-1:0]              out_valid,
  input  logic [N-1:0]              out_ready,
  output logic [N-1:0][WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]          out_sel
);

  logic [N-1:0]            r_full;
  logic [N-1:0][WIDTH-1:0] r_data;
  logic [SEL_W-1:0]        r_ptr;

  logic [N-1:0]            w_avail;
  logic [N-1:0]            w_load;
  logic [SEL_W-1:0]        w_sel;
  logic                    w_found;
  logic                    w_accept;

  // A full slot whose consumer is taking it this cycle can be refilled immediately.
  assign w_avail = ~r_full | out_ready;

  // Two passes: indices at or above the pointer first, then wrap to the low indices.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_avail[i] && (SEL_W'(i) >= r_ptr)) begin
        w_sel   = SEL_W'(i);
        w_found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_avail[i]) begin
        w_sel   = SEL_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign in_ready = rst_n & w_found;
  assign out_sel  = in_ready ? w_sel : '0;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < N; i++) begin
      w_load[i] = w_accept && (w_sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_sel == SEL_W'(N - 1)) ? '0 : w_sel + SEL_W'(1);
    end
  end

  // A load wins over a drain so a slot reloaded while emptying stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_data <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_load[i]) begin
          r_full[i] <= 1'b1;
          r_data[i] <= in_data;
        end else if (out_ready[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_full;
  assign out_data  = r_data;

endmodule

// File: tb/tb_pyc_rr_dist.sv
// Directed bench for pyc_rr_dist: a 4-way/8-bit instance with a per-cycle monitor,
// plus a 1-way instance exercised as a plain pipeline register.
module tb_pyc_rr_dist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic            v4, ir4;
  logic [7:0]      d4;
  logic [3:0]      ov4, rdy4;
  logic [3:0][7:0] od4;
  logic [1:0]      sel4;

  logic            v1, ir1;
  logic [7:0]      d1;
  logic [0:0]      ov1, rdy1;
  logic [0:0][7:0] od1;
  logic [0:0]      sel1;

  int checks   = 0;
  int failures = 0;
  int acc1     = 0;
  logic mon_en = 1'b0;

  pyc_rr_dist #(.WIDTH(8), .N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(ir4), .in_data(d4),
    .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .out_sel(sel4)
  );

  pyc_rr_dist #(.WIDTH(8), .N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .out_valid(ov1), .out_ready(rdy1), .out_data(od1), .out_sel(sel1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_sel(input logic [3:0] av, input logic [1:0] ptr);
    logic [1:0] ix;
    for (int k = 0; k < 4; k++) begin
      ix = ptr + 2'(k);
      if (av[ix]) return ix;
    end
    return 2'd0;
  endfunction

  // Reset asserted between edges; outputs must drop before the next edge.
  task automatic reset_pulse();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("RST_valid", 32'(ov4), 0);
    chk("RST_ready", 32'(ir4), 0);
    chk("RST_sel",   32'(sel4), 0);
    chk("RST_data",  32'(od4), 0);
    chk("RST_ready1", 32'(ir1), 0);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  // Per-cycle monitor for the 4-way instance.
  logic            p_ok = 1'b0;
  logic [3:0]      p_full, p_rdy;
  logic [3:0][7:0] p_data;
  logic            p_acc;
  logic [1:0]      p_sel, m_ptr, m_sel;
  logic [7:0]      p_in;
  logic [3:0]      m_av;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      p_ok  = 1'b0;
      m_ptr = 2'd0;
    end else begin
      if (p_ok) begin
        for (int i = 0; i < 4; i++) begin
          if (p_full[i] && !p_rdy[i]) begin
            chk("M_hold_v", 32'(ov4[i]), 1);
            chk("M_hold_d", 32'(od4[i]), 32'(p_data[i]));
          end
        end
        if (p_acc) begin
          chk("M_land_v", 32'(ov4[p_sel]), 1);
          chk("M_land_d", 32'(od4[p_sel]), 32'(p_in));
        end
      end
      m_av  = ~ov4 | rdy4;
      m_sel = model_sel(m_av, m_ptr);
      chk("M_ready", 32'(ir4), 32'(|m_av));
      if (|m_av) chk("M_sel", 32'(sel4), 32'(m_sel));
      p_ok   = 1'b1;
      p_full = ov4;
      p_rdy  = rdy4;
      p_data = od4;
      p_acc  = v4 && ir4;
      p_sel  = sel4;
      p_in   = d4;
      if (p_acc) m_ptr = m_sel + 2'd1;
    end
  end

  logic [1:0] ix;

  initial begin
    rst_n = 1'b0;
    v4 = 1'b0; d4 = 8'h00; rdy4 = 4'h0;
    v1 = 1'b0; d1 = 8'h00; rdy1 = 1'b0;

    @(posedge clk); #1;
    chk("R0_valid", 32'(ov4), 0);
    chk("R0_data",  32'(od4), 0);
    chk("R0_ready", 32'(ir4), 0);
    chk("R0_sel",   32'(sel4), 0);
    chk("R0_valid1", 32'(ov1), 0);
    @(negedge clk); #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // All consumers ready: one accept per cycle, outputs 0,1,2,3,0.
    rdy4 = 4'hF;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      v4 = 1'b1;
      d4 = 8'(8'h10 + k);
      @(negedge clk);
      chk("A_ready", 32'(ir4), 1);
      chk("A_sel", 32'(sel4), 32'(k % 4));
      if (k > 0) begin
        ix = 2'(k - 1);
        chk("A_valid", 32'(ov4[ix]), 1);
        chk("A_data", 32'(od4[ix]), 32'(8'h10 + k - 1));
      end
      @(posedge clk); #1;
    end
    v4 = 1'b0;
    @(negedge clk);
    chk("A_last_valid", 32'(ov4), 32'h1);
    chk("A_last_data", 32'(od4[0]), 32'h14);

    // Fill all slots with consumers stalled, then free slot 2.
    reset_pulse();
    rdy4 = 4'h0;
    for (int k = 0; k < 4; k++) begin
      v4 = 1'b1;
      d4 = 8'(8'hA0 + k);
      @(negedge clk);
      chk("B_ready", 32'(ir4), 1);
      chk("B_sel", 32'(sel4), 32'(k));
      @(posedge clk); #1;
    end
    d4 = 8'hA4;
    @(negedge clk);
    chk("B_full_ready", 32'(ir4), 0);
    chk("B_full_sel", 32'(sel4), 0);
    chk("B_full_valid", 32'(ov4), 32'hF);
    for (int i = 0; i < 4; i++) chk("B_slot_data", 32'(od4[i]), 32'(8'hA0 + i));
    @(posedge clk); #1;
    rdy4 = 4'b0100;
    @(negedge clk);
    chk("B_pulse_ready", 32'(ir4), 1);
    chk("B_pulse_sel", 32'(sel4), 2);
    @(posedge clk); #1;
    v4 = 1'b0;
    rdy4 = 4'hF;
    @(negedge clk);
    chk("B_reload_valid", 32'(ov4), 32'hF);
    chk("B_reload_data", 32'(od4[2]), 32'hA4);
    chk("B_next_ptr", 32'(sel4), 3);
    @(posedge clk); #1;

    // Pointer at 1 with slot 1 stuck full: dispatch skips to slot 2.
    reset_pulse();
    rdy4 = 4'h0;
    for (int k = 0; k < 4; k++) begin
      v4 = 1'b1;
      d4 = 8'(8'hB0 + k);
      @(posedge clk); #1;
    end
    d4 = 8'hB4;
    rdy4 = 4'b0001;
    @(negedge clk);
    chk("C_reload_sel", 32'(sel4), 0);
    @(posedge clk); #1;
    v4 = 1'b0;
    rdy4 = 4'b1100;
    @(negedge clk);
    chk("C_nobubble_valid", 32'(ov4), 32'hF);
    chk("C_nobubble_data", 32'(od4[0]), 32'hB4);
    @(posedge clk); #1;
    rdy4 = 4'h0;
    v4 = 1'b1;
    d4 = 8'hC0;
    @(negedge clk);
    chk("C_pre_valid", 32'(ov4), 32'b0011);
    chk("C_ready", 32'(ir4), 1);
    chk("C_sel", 32'(sel4), 2);
    @(posedge clk); #1;
    v4 = 1'b0;
    @(negedge clk);
    chk("C_post_valid", 32'(ov4), 32'b0111);
    chk("C_post_data", 32'(od4[2]), 32'hC0);
    chk("C_next_ptr", 32'(sel4), 3);

    // Mid-operation reset with slots full; first item afterwards goes to slot 0.
    reset_pulse();
    v4 = 1'b1;
    d4 = 8'h55;
    rdy4 = 4'h0;
    @(negedge clk);
    chk("D_ready", 32'(ir4), 1);
    chk("D_sel", 32'(sel4), 0);
    chk("D_empty", 32'(ov4), 0);
    @(posedge clk); #1;
    v4 = 1'b0;
    @(negedge clk);
    chk("D_valid", 32'(ov4), 32'b0001);
    chk("D_data", 32'(od4[0]), 32'h55);

    // Single-output instance: full-throughput pipeline register.
    reset_pulse();
    rdy1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      v1 = 1'b1;
      d1 = 8'(8'h60 + k);
      @(negedge clk);
      chk("E_ready", 32'(ir1), 1);
      chk("E_sel", 32'(sel1), 0);
      if (v1 && ir1) acc1++;
      if (k > 0) begin
        chk("E_valid", 32'(ov1), 1);
        chk("E_data", 32'(od1), 32'(8'h60 + k - 1));
      end
      @(posedge clk); #1;
    end
    rdy1 = 1'b0;
    d1 = 8'h70;
    @(negedge clk);
    chk("E_accepts", 32'(acc1), 8);
    chk("E_last_data", 32'(od1), 32'h67);
    chk("E_stall_ready", 32'(ir1), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("E_hold_data", 32'(od1), 32'h67);
    chk("E_hold_valid", 32'(ov1), 1);
    chk("E_hold_ready", 32'(ir1), 0);
    v1 = 1'b0;

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
